pred_lead: RTL and testbench



---
 rtl/pred_lead.sv | 143 ++++++++++++++
 tb/tb_pred_lead.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pred_lead.sv
// pred_lead: phase-lead predictor for the DRSSTC primary-current feedback.
// The raw sign is synchronised and each half-period is measured. Once enough
// consecutive clean edges have been seen, the output is flipped a programmable
// number of cycles ahead of the expected zero crossing. Without lock, or in
// delay mode, the output follows the synchronised sign through a
// pulse-filtering delay counter.
`timescale 1ns/1ps

module pred_lead #(
    parameter int CNT_WIDTH   = 10,
    parameter int SYNC_STAGES = 2,
    parameter int MIN_HALF    = 8,
    parameter int LOCK_EDGES  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 sgn,
    input  logic                 mode,
    input  logic [CNT_WIDTH-1:0] lead,
    output logic                 sgn_pre,
    output logic                 locked,
    output logic [CNT_WIDTH-1:0] period_meas
);

    localparam int                   EC_W       = $clog2(LOCK_EDGES + 1);
    localparam logic [CNT_WIDTH-1:0] HP_MAX     = '1;
    localparam logic [CNT_WIDTH-1:0] MIN_HALF_C = CNT_WIDTH'(MIN_HALF);
    localparam logic [EC_W-1:0]      LOCK_C     = EC_W'(LOCK_EDGES);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_sgn_s_d;
    logic [CNT_WIDTH-1:0]   r_hp_cnt;
    logic [CNT_WIDTH-1:0]   r_period_meas;
    logic [EC_W-1:0]        r_edge_cnt;
    logic                   r_locked;
    logic                   r_sgn_pre;
    logic [CNT_WIDTH-1:0]   r_dly_cnt;

    logic                   w_sgn_s;
    logic                   w_edge;
    logic                   w_acc;
    logic                   w_glitch;
    logic                   w_timeout;
    logic                   w_pred;
    logic [CNT_WIDTH-1:0]   w_pm_m1;
    logic [CNT_WIDTH-1:0]   w_lead_eff;
    logic [CNT_WIDTH-1:0]   w_match_pt;
    logic                   w_match;

    assign w_sgn_s   = r_sync[SYNC_STAGES-1];
    assign w_edge    = w_sgn_s ^ r_sgn_s_d;
    assign w_acc     = w_edge && (r_hp_cnt >= MIN_HALF_C);
    assign w_glitch  = w_edge && (r_hp_cnt < MIN_HALF_C);
    assign w_timeout = (r_hp_cnt == HP_MAX);
    assign w_pred    = mode && r_locked;

    // Lead is clamped below the measured period so the match point never wraps.
    assign w_pm_m1    = r_period_meas - CNT_WIDTH'(1);
    assign w_lead_eff = (lead > w_pm_m1) ? w_pm_m1 : lead;
    assign w_match_pt = r_period_meas - w_lead_eff;
    assign w_match    = (r_hp_cnt == w_match_pt);

    assign sgn_pre     = r_sgn_pre;
    assign locked      = r_locked;
    assign period_meas = r_period_meas;

    // Synchroniser chain plus one delayed copy for edge detection; runs even when disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync    <= '0;
            r_sgn_s_d <= 1'b0;
        end else begin
            r_sync    <= {r_sync[SYNC_STAGES-2:0], sgn};
            r_sgn_s_d <= w_sgn_s;
        end
    end

    // Half-period counter: restarts at 1 on an accepted edge, saturates at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hp_cnt      <= '0;
            r_period_meas <= '0;
        end else if (!en) begin
            r_hp_cnt      <= '0;
        end else if (w_acc) begin
            r_period_meas <= r_hp_cnt;
            r_hp_cnt      <= CNT_WIDTH'(1);
        end else if (!w_timeout) begin
            r_hp_cnt      <= r_hp_cnt + CNT_WIDTH'(1);
        end
    end

    // Lock tracking: count clean edges, drop lock on a glitch or a stalled input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_edge_cnt <= '0;
            r_locked   <= 1'b0;
        end else if (!en) begin
            r_edge_cnt <= '0;
            r_locked   <= 1'b0;
        end else if (w_acc) begin
            if (r_edge_cnt < LOCK_C) begin
                r_edge_cnt <= r_edge_cnt + EC_W'(1);
                if ((r_edge_cnt + EC_W'(1)) == LOCK_C) begin
                    r_locked <= 1'b1;
                end
            end
        end else if (w_glitch || w_timeout) begin
            r_edge_cnt <= '0;
            r_locked   <= 1'b0;
        end
    end

    // Output path: predictive toggle when locked in mode 1, otherwise filtered delay-follow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sgn_pre <= 1'b0;
            r_dly_cnt <= '0;
        end else if (!en) begin
            r_sgn_pre <= 1'b0;
            r_dly_cnt <= lead;
        end else if (w_pred) begin
            // Delay counter is parked at lead so a fall-back starts a fresh count.
            r_dly_cnt <= lead;
            if (w_acc) begin
                r_sgn_pre <= w_sgn_s;
            end else if (w_match) begin
                r_sgn_pre <= ~w_sgn_s;
            end
        end else if (w_sgn_s != r_sgn_pre) begin
            if (r_dly_cnt == '0) begin
                r_sgn_pre <= w_sgn_s;
                r_dly_cnt <= lead;
            end else begin
                r_dly_cnt <= r_dly_cnt - CNT_WIDTH'(1);
            end
        end else begin
            r_dly_cnt <= lead;
        end
    end

endmodule

// File: tb/tb_pred_lead.sv
`timescale 1ns/1ps

module tb_pred_lead;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       sgn;
    logic       mode;
    logic [9:0] lead;
    logic       sgn_pre;
    logic       locked;
    logic [9:0] period_meas;

    pred_lead #(
        .CNT_WIDTH  (10),
        .SYNC_STAGES(2),
        .MIN_HALF   (8),
        .LOCK_EDGES (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .sgn        (sgn),
        .mode       (mode),
        .lead       (lead),
        .sgn_pre    (sgn_pre),
        .locked     (locked),
        .period_meas(period_meas)
    );

    typedef struct {
        int   cyc;
        logic val;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    logic prev = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic push(input int c, input logic v);
        exp_t e;
        e.cyc = c;
        e.val = v;
        q.push_back(e);
    endtask

    task automatic wcyc(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic tog(output int n);
        sgn = ~sgn;
        n = cyc;
    endtask

    task automatic release_rst();
        sgn = 1'b0;
        en  = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic end_phase(input string nm, input int settle);
        wcyc(settle);
        check(nm, q.size(), 0);
        q.delete();
        @(negedge clk);
        #2 rst_n = 1'b0;
        release_rst();
    endtask

    // Monitor: every sgn_pre transition must match the next scheduled expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev = sgn_pre;
        end else if (sgn_pre !== prev) begin
            prev = sgn_pre;
            if (q.size() == 0) begin
                n_checks++;
                $display("FAIL sgn_pre_unexpected: got edge to %0d at cycle %0d expected none", sgn_pre, cyc);
            end else begin
                e = q.pop_front();
                check("sgn_pre_cyc", cyc, e.cyc);
                check("sgn_pre_val", int'(sgn_pre), int'(e.val));
            end
        end
    end

    initial begin
        int n;
        int m;
        rst_n = 1'b1;
        en    = 1'b0;
        sgn   = 1'b0;
        mode  = 1'b0;
        lead  = '0;
        #1 rst_n = 1'b0;
        release_rst();

        // Idle with en low, then lead=0 follow, then asynchronous reset mid-stream
        wcyc(3);
        sgn = 1'b1;
        wcyc(10);
        check("idle_sgn_pre", int'(sgn_pre), 0);
        check("idle_locked", int'(locked), 0);
        mode = 1'b0;
        lead = 10'd0;
        en   = 1'b1;
        m    = cyc;
        push(m + 1, 1'b1);
        wcyc(20);
        tog(n); push(n + 3, sgn);
        wcyc(20);
        tog(n); push(n + 3, sgn);
        wcyc(5);
        check("follow_pm", int'(period_meas), 20);
        tog(n);
        wcyc(1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_sgn_pre", int'(sgn_pre), 0);
        check("rst_locked", int'(locked), 0);
        check("rst_pm", int'(period_meas), 0);
        check("rst_queue", q.size(), 0);
        release_rst();

        // Delay mode, lead=5, half-period 40, then a 3-cycle pulse
        mode = 1'b0;
        lead = 10'd5;
        en   = 1'b1;
        wcyc(10);
        for (int k = 0; k < 4; k++) begin
            tog(n); push(n + 8, sgn);
            wcyc(40);
        end
        check("dly_locked", int'(locked), 1);
        tog(n);
        wcyc(3);
        tog(n);
        wcyc(30);
        check("dly_glitch_unlock", int'(locked), 0);
        check("dly_glitch_pm", int'(period_meas), 40);
        end_phase("dly_drain", 10);

        // Predictive mode: lock at half-period 50, glitch, relock
        mode = 1'b1;
        lead = 10'd10;
        en   = 1'b1;
        wcyc(10);
        for (int k = 1; k <= 7; k++) begin
            tog(n);
            if (k <= 3) push(n + 13, sgn);
            else if (k >= 5) push(n + 43, ~sgn);
            if (k == 4) begin
                wcyc(2);
                check("lock_pre", int'(locked), 0);
                wcyc(1);
                check("lock_rise", int'(locked), 1);
                wcyc(47);
            end else begin
                wcyc(50);
            end
        end
        check("lock_pm", int'(period_meas), 50);
        tog(n);
        wcyc(2);
        tog(n);
        wcyc(3);
        tog(n);
        wcyc(5);
        check("glitch_locked", int'(locked), 0);
        check("glitch_pm", int'(period_meas), 50);
        wcyc(40);
        for (int k = 1; k <= 4; k++) begin
            tog(n);
            if (k <= 3) push(n + 13, sgn);
            if (k == 4) begin
                wcyc(2);
                check("relock_pre", int'(locked), 0);
                wcyc(1);
                check("relock_rise", int'(locked), 1);
                wcyc(47);
            end else begin
                wcyc(50);
            end
        end
        end_phase("lock_drain", 10);

        // Lead clamp (lead=100, half-period 30) and timeout
        mode = 1'b1;
        lead = 10'd100;
        en   = 1'b1;
        wcyc(10);
        for (int k = 1; k <= 5; k++) begin
            tog(n);
            if (k >= 4) push(n + 4, ~sgn);
            wcyc(30);
        end
        tog(n);
        push(n + 4, ~sgn);
        push(n + 1127, sgn);
        wcyc(1025);
        check("timeout_pre", int'(locked), 1);
        wcyc(1);
        check("timeout_unlock", int'(locked), 0);
        check("clamp_pm", int'(period_meas), 30);
        end_phase("clamp_drain", 110);

        // Frequency step 50 -> 60, then an edge coinciding with the match point
        mode = 1'b1;
        lead = 10'd10;
        en   = 1'b1;
        wcyc(10);
        for (int k = 1; k <= 6; k++) begin
            tog(n);
            if (k <= 3) push(n + 13, sgn);
            else if (k >= 5) push(n + 43, ~sgn);
            wcyc(k == 6 ? 60 : 50);
        end
        tog(n);
        push(n + 53, ~sgn);
        wcyc(3);
        check("step_pm", int'(period_meas), 60);
        wcyc(57);
        tog(n);
        wcyc(50);
        tog(n);
        push(n + 3, sgn);
        push(n + 43, ~sgn);
        wcyc(50);
        tog(n);
        push(n + 43, ~sgn);
        end_phase("step_drain", 60);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
